mc_control_fsm: RTL and testbench

Multi-cycle control unit that drives the control inputs of the MIPS datapath top (RegDst, RegWrite, ALUsrc, MemWrite, MemRead, MemToReg, alu_control).
- Decodes the latched instruction word and sequences FETCH/DECODE/EXEC/MEM/WB.
- Waits on a memory ready handshake in memory-access states.
- Counts retired instructions.
- Flags illegal opcodes.

---
 rtl/mips_ctrl_pkg.sv | 64 ++++++
 rtl/alu_dec.sv | 28 ++
 rtl/mc_control_fsm.sv | 168 ++++++++++++++++
 tb/tb_mc_control_fsm.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared control constants for the MIPS multi-cycle and single-cycle datapaths:
// ALU op codes, opcode/funct values, PC source encodings, FSM states.
package mips_ctrl_pkg;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_XOR = 5'd4;
  localparam logic [4:0] ALU_NOR = 5'd5;
  localparam logic [4:0] ALU_SLT = 5'd6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_BRANCH,
    S_JUMP
  } state_t;

  typedef enum logic [2:0] {
    IC_RTYPE,
    IC_LW,
    IC_SW,
    IC_ADDI,
    IC_BEQ,
    IC_J,
    IC_ILLEGAL
  } instr_class_t;

  function automatic instr_class_t decode_opcode(input logic [5:0] opcode);
    case (opcode)
      OP_RTYPE: return IC_RTYPE;
      OP_LW:    return IC_LW;
      OP_SW:    return IC_SW;
      OP_ADDI:  return IC_ADDI;
      OP_BEQ:   return IC_BEQ;
      OP_J:     return IC_J;
      default:  return IC_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/alu_dec.sv
// R-type funct decoder: maps funct to an ALU operation and flags unsupported
// funct codes. Purely combinational so the single-cycle datapath can reuse it.
module alu_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [4:0] alu_control,
  output logic       legal
);

  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves it
    // unassigned and no latch is inferred.
    alu_control = ALU_ADD;
    legal       = 1'b1;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_XOR:  alu_control = ALU_XOR;
      FN_NOR:  alu_control = ALU_NOR;
      FN_SLT:  alu_control = ALU_SLT;
      default: legal       = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB (plus
// BRANCH/JUMP), waits on mem_ready, counts retired instructions, flags illegal ones.
module mc_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             iszero,
  input  logic             mem_ready,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUsrc,
  output logic             MemWrite,
  output logic             MemRead,
  output logic             MemToReg,
  output logic [4:0]       alu_control,
  output logic             IorD,
  output logic             IRWrite,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] retired
);

  state_t       state, next_state;
  instr_class_t iclass;
  logic [4:0]   funct_alu;
  logic         funct_legal;
  logic         retire;

  // Only opcode and funct steer control; the register/immediate fields are datapath-only.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[25:6];

  assign iclass = decode_opcode(instr[31:26]);

  alu_dec u_alu_dec (
    .funct       (instr[5:0]),
    .alu_control (funct_alu),
    .legal       (funct_legal)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all registered state so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state   <= S_FETCH;
      retired <= '0;
    end else begin
      state <= next_state;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    next_state    = state;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    ALUsrc        = 1'b0;
    MemWrite      = 1'b0;
    MemRead       = 1'b0;
    MemToReg      = 1'b0;
    alu_control   = ALU_ADD;
    IorD          = 1'b0;
    IRWrite       = 1'b0;
    pc_en         = 1'b0;
    pc_src        = PC_SRC_SEQ;
    illegal_instr = 1'b0;
    retire        = 1'b0;

    unique case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          pc_en      = 1'b1;
          next_state = S_DECODE;
        end
      end

      S_DECODE: begin
        case (iclass)
          IC_RTYPE: begin
            if (funct_legal) begin
              next_state = S_EXEC;
            end else begin
              illegal_instr = 1'b1;
              next_state    = S_FETCH;
            end
          end
          IC_LW, IC_SW, IC_ADDI: next_state = S_EXEC;
          IC_BEQ:                next_state = S_BRANCH;
          IC_J:                  next_state = S_JUMP;
          default: begin
            illegal_instr = 1'b1;
            next_state    = S_FETCH;
          end
        endcase
      end

      S_EXEC: begin
        if (iclass == IC_RTYPE) begin
          alu_control = funct_alu;
        end else begin
          ALUsrc = 1'b1;
        end
        next_state = (iclass == IC_LW || iclass == IC_SW) ? S_MEM : S_WB;
      end

      // Strobes stay up every waiting cycle; the access completes only on mem_ready.
      S_MEM: begin
        IorD     = 1'b1;
        ALUsrc   = 1'b1;
        MemRead  = (iclass == IC_LW);
        MemWrite = (iclass == IC_SW);
        if (mem_ready) begin
          if (iclass == IC_LW) begin
            next_state = S_WB;
          end else begin
            retire     = 1'b1;
            next_state = S_FETCH;
          end
        end
      end

      S_WB: begin
        RegWrite   = 1'b1;
        RegDst     = (iclass == IC_RTYPE);
        MemToReg   = (iclass == IC_LW);
        retire     = 1'b1;
        next_state = S_FETCH;
      end

      S_BRANCH: begin
        alu_control = ALU_SUB;
        pc_en       = iszero;
        pc_src      = PC_SRC_BRANCH;
        retire      = 1'b1;
        next_state  = S_FETCH;
      end

      S_JUMP: begin
        pc_en      = 1'b1;
        pc_src     = PC_SRC_JUMP;
        retire     = 1'b1;
        next_state = S_FETCH;
      end

      default: next_state = S_FETCH;
    endcase

    // Reset overrides the decode so an in-flight instruction aborts without writing.
    if (rst) begin
      RegWrite      = 1'b0;
      MemWrite      = 1'b0;
      MemRead       = 1'b0;
      IRWrite       = 1'b0;
      pc_en         = 1'b0;
      illegal_instr = 1'b0;
      alu_control   = ALU_ADD;
      retire        = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench for mc_control_fsm: a per-instruction cycle plan derived
// from the instruction's phases is compared against the DUT every cycle.
module tb_mc_control_fsm;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      instr;
  logic             iszero;
  logic             mem_ready;
  logic             RegDst, RegWrite, ALUsrc, MemWrite, MemRead, MemToReg;
  logic [4:0]       alu_control;
  logic             IorD, IRWrite, pc_en;
  logic [1:0]       pc_src;
  logic             illegal_instr;
  logic [CNT_W-1:0] retired;

  mc_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr         (instr),
    .iszero        (iszero),
    .mem_ready     (mem_ready),
    .RegDst        (RegDst),
    .RegWrite      (RegWrite),
    .ALUsrc        (ALUsrc),
    .MemWrite      (MemWrite),
    .MemRead       (MemRead),
    .MemToReg      (MemToReg),
    .alu_control   (alu_control),
    .IorD          (IorD),
    .IRWrite       (IRWrite),
    .pc_en         (pc_en),
    .pc_src        (pc_src),
    .illegal_instr (illegal_instr),
    .retired       (retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic [4:0] alu;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       illegal;
  } outs_t;

  typedef struct {
    logic  mr;
    logic  iz;
    outs_t exp;
    bit    retire;
  } step_t;

  outs_t            got;
  step_t            plan[$];
  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] exp_retired;
  logic [5:0]       fn_tab [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};

  assign got = {RegDst, RegWrite, ALUsrc, MemWrite, MemRead, MemToReg, alu_control,
                IorD, IRWrite, pc_en, pc_src, illegal_instr};

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got_v, exp_v);
    end
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // ALU code is the position of the funct in the supported table, -1 if absent.
  function automatic int alu_of(input logic [5:0] fn);
    for (int i = 0; i < 7; i++) if (fn_tab[i] == fn) return i;
    return -1;
  endfunction

  task automatic push(input logic mr, input logic iz, input outs_t o, input bit ret);
    step_t s;
    s.mr = mr; s.iz = iz; s.exp = o; s.retire = ret;
    plan.push_back(s);
  endtask

  // wf/wm: mem_ready-low cycles in fetch / memory phase; bz forces branch iszero (-1 = random).
  task automatic build_plan(input logic [31:0] iw, input int wf, input int wm, input int bz);
    logic [5:0] op;
    int         fn_idx;
    bit         is_r, is_lw, is_sw, is_addi, is_beq, is_j, legal;
    logic       iz;
    outs_t      o;
    op      = iw[31:26];
    fn_idx  = alu_of(iw[5:0]);
    is_r    = (op == 6'h00);
    is_lw   = (op == 6'h23);
    is_sw   = (op == 6'h2B);
    is_addi = (op == 6'h08);
    is_beq  = (op == 6'h04);
    is_j    = (op == 6'h02);
    legal   = (is_r && fn_idx >= 0) || is_lw || is_sw || is_addi || is_beq || is_j;
    plan.delete();
    for (int i = 0; i < wf; i++) begin
      o = '0; o.mem_read = 1'b1;
      push(1'b0, rnd(), o, 1'b0);
    end
    o = '0; o.mem_read = 1'b1; o.ir_write = 1'b1; o.pc_en = 1'b1;
    push(1'b1, rnd(), o, 1'b0);
    o = '0; o.illegal = !legal;
    push(rnd(), rnd(), o, 1'b0);
    if (!legal) return;
    if (is_beq) begin
      iz = (bz < 0) ? rnd() : 1'(bz);
      o = '0; o.alu = 5'd1; o.pc_en = iz; o.pc_src = 2'b01;
      push(rnd(), iz, o, 1'b1);
      return;
    end
    if (is_j) begin
      o = '0; o.pc_en = 1'b1; o.pc_src = 2'b10;
      push(rnd(), rnd(), o, 1'b1);
      return;
    end
    o = '0; o.alu_src = !is_r; o.alu = is_r ? 5'(fn_idx) : 5'd0;
    push(rnd(), rnd(), o, 1'b0);
    if (is_lw || is_sw) begin
      o = '0; o.iord = 1'b1; o.alu_src = 1'b1; o.mem_read = is_lw; o.mem_write = is_sw;
      for (int i = 0; i < wm; i++) push(1'b0, rnd(), o, 1'b0);
      push(1'b1, rnd(), o, is_sw);
      if (is_sw) return;
    end
    o = '0; o.reg_write = 1'b1; o.reg_dst = is_r; o.mem_to_reg = is_lw;
    push(rnd(), rnd(), o, 1'b1);
  endtask

  // Entered one time unit after a rising edge with the DUT expected in FETCH.
  task automatic run_instr(input logic [31:0] iw, input int wf, input int wm, input int bz);
    build_plan(iw, wf, wm, bz);
    instr = iw;
    foreach (plan[i]) begin
      mem_ready = plan[i].mr;
      iszero    = plan[i].iz;
      @(negedge clk);
      check("outs", 32'(got), 32'(plan[i].exp));
      @(posedge clk);
      #1;
      if (plan[i].retire) exp_retired = exp_retired + CNT_W'(1);
      check("retired", retired, exp_retired);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] iw;
    logic [5:0]  op;
    int          k;
    iw = $urandom;
    k  = $urandom_range(0, 9);
    case (k)
      0, 1, 9: begin op = 6'h00; iw[5:0] = fn_tab[$urandom_range(0, 6)]; end
      2:       begin op = 6'h00; iw[5:0] = 6'($urandom); end
      3:       op = 6'h23;
      4:       op = 6'h2B;
      5:       op = 6'h08;
      6:       op = 6'h04;
      7:       op = 6'h02;
      default: begin
        op = 6'($urandom);
        while (op == 6'h00 || op == 6'h02 || op == 6'h04 || op == 6'h08 ||
               op == 6'h23 || op == 6'h2B) op = 6'($urandom);
      end
    endcase
    iw[31:26] = op;
    return iw;
  endfunction

  function automatic int rand_wait();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
  endfunction

  initial begin
    outs_t o;
    rst         = 1'b1;
    mem_ready   = 1'b1;
    iszero      = 1'b0;
    instr       = 32'h0;
    exp_retired = '0;

    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_outs", 32'(got), 32'h0);
      check("rst_retired", retired, 32'h0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_instr({6'h00, 20'h12345, 6'h20}, 0, 0, -1);  // add
    run_instr({6'h23, 26'h0ABCDEF},      0, 2, -1);  // lw, 2 wait cycles in MEM
    run_instr({6'h2B, 26'h1234567},      0, 1, -1);  // sw
    run_instr({6'h04, 26'h0000010},      0, 0, 1);   // beq taken
    run_instr({6'h04, 26'h0000020},      0, 0, 0);   // beq not taken
    run_instr({6'h3F, 26'h3FFFFFF},      0, 0, -1);  // illegal opcode
    run_instr({6'h00, 20'hFFFFF, 6'h01}, 0, 0, -1);  // illegal funct
    run_instr({6'h02, 26'h2000000},      2, 0, -1);  // j after fetch stall

    for (int n = 0; n < 300; n++) run_instr(rand_instr(), rand_wait(), rand_wait(), -1);

    // Reset while sw waits in MEM: write strobe must drop and the store must not retire.
    instr     = {6'h2B, 26'h0000040};
    mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    o = '0; o.iord = 1'b1; o.alu_src = 1'b1; o.mem_write = 1'b1;
    check("sw_mem_wait", 32'(got), 32'(o));
    @(posedge clk);
    #1;
    rst       = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    check("rst_mem_strobes", {26'h0, RegWrite, MemWrite, MemRead, IRWrite, pc_en, illegal_instr}, 32'h0);
    check("rst_mem_alu", 32'(alu_control), 32'h0);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    exp_retired = '0;
    check("rst_mem_retired", retired, exp_retired);
    mem_ready = 1'b0;
    @(negedge clk);
    o = '0; o.mem_read = 1'b1;
    check("after_rst_fetch", 32'(got), 32'(o));
    @(posedge clk);
    #1;

    for (int n = 0; n < 20; n++) run_instr(rand_instr(), rand_wait(), rand_wait(), -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
